// File: rtl/tetris_video_pkg.sv
// Shared board geometry, colour-index type and RGB palette for the Tetris video path.
package tetris_video_pkg;

    localparam int BOARD_COLS  = 10;
    localparam int BOARD_ROWS  = 20;
    localparam int BOARD_CELLS = BOARD_COLS * BOARD_ROWS;
    localparam int COL_W       = 4;
    localparam int ROW_W       = 5;
    localparam int CELL_AW     = 8;

    typedef enum logic [2:0] {
        CLR_EMPTY  = 3'd0,
        CLR_CYAN   = 3'd1,
        CLR_YELLOW = 3'd2,
        CLR_PURPLE = 3'd3,
        CLR_GREEN  = 3'd4,
        CLR_RED    = 3'd5,
        CLR_BLUE   = 3'd6,
        CLR_ORANGE = 3'd7
    } color_idx_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK = 24'h000000;
    localparam rgb_t BG_RGB    = 24'h111111;
    localparam rgb_t GRID_RGB  = 24'h404040;

    localparam rgb_t PAL_CYAN   = 24'h00FFFF;
    localparam rgb_t PAL_YELLOW = 24'hFFFF00;
    localparam rgb_t PAL_PURPLE = 24'h8000FF;
    localparam rgb_t PAL_GREEN  = 24'h00FF00;
    localparam rgb_t PAL_RED    = 24'hFF0000;
    localparam rgb_t PAL_BLUE   = 24'h0000FF;
    localparam rgb_t PAL_ORANGE = 24'hFF8000;

    function automatic rgb_t palette_lookup(input color_idx_t c);
        rgb_t rgb;
        case (c)
            CLR_CYAN:   rgb = PAL_CYAN;
            CLR_YELLOW: rgb = PAL_YELLOW;
            CLR_PURPLE: rgb = PAL_PURPLE;
            CLR_GREEN:  rgb = PAL_GREEN;
            CLR_RED:    rgb = PAL_RED;
            CLR_BLUE:   rgb = PAL_BLUE;
            CLR_ORANGE: rgb = PAL_ORANGE;
            default:    rgb = RGB_BLACK;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/tetris_board_ram.sv
// 10x20 board of colour indices: synchronous write, registered read, asynchronous clear.
module tetris_board_ram
    import tetris_video_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [COL_W-1:0] wr_col,
    input  logic [ROW_W-1:0] wr_row,
    input  color_idx_t       wr_color,
    input  logic [COL_W-1:0] rd_col,
    input  logic [ROW_W-1:0] rd_row,
    output color_idx_t       rd_color
);

    color_idx_t         cell_reg [BOARD_CELLS];
    color_idx_t         rd_color_reg;
    logic               wr_ok;
    logic               rd_ok;
    logic [CELL_AW-1:0] wr_idx;
    logic [CELL_AW-1:0] rd_idx;

    // Row-major linear index; out-of-range addresses are rejected before they can alias.
    assign wr_ok  = wr_en && (wr_col < COL_W'(BOARD_COLS)) && (wr_row < ROW_W'(BOARD_ROWS));
    assign rd_ok  = (rd_col < COL_W'(BOARD_COLS)) && (rd_row < ROW_W'(BOARD_ROWS));
    assign wr_idx = CELL_AW'(wr_row) * CELL_AW'(BOARD_COLS) + CELL_AW'(wr_col);
    assign rd_idx = CELL_AW'(rd_row) * CELL_AW'(BOARD_COLS) + CELL_AW'(rd_col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BOARD_CELLS; i++) begin
                cell_reg[i] <= CLR_EMPTY;
            end
        end else if (wr_ok) begin
            cell_reg[wr_idx] <= wr_color;
        end
    end

    // Read samples the pre-write contents, so a same-edge write shows up on the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_color_reg <= CLR_EMPTY;
        end else if (rd_ok) begin
            rd_color_reg <= cell_reg[rd_idx];
        end else begin
            rd_color_reg <= CLR_EMPTY;
        end
    end

    assign rd_color = rd_color_reg;

endmodule

// File: rtl/tetris_pixel_renderer.sv
// Two-stage pixel renderer overlaying the Tetris board on the video stream.
// Define TETRIS_GRID_LINES_EN to draw grid lines on the first row/column of every cell.
module tetris_pixel_renderer
    import tetris_video_pkg::*;
#(
    parameter int ORIGIN_X   = 240,
    parameter int ORIGIN_Y   = 80,
    parameter int CELL_SHIFT = 4
) (
    input  logic       pixclk,
    input  logic       rst_n,
    input  logic       vde_in,
    input  logic [1:0] cd_in,
    input  logic [9:0] x_in,
    input  logic [9:0] y_in,
    input  logic       wr_en,
    input  logic [3:0] wr_col,
    input  logic [4:0] wr_row,
    input  logic [2:0] wr_color,
    output logic       vde_out,
    output logic [1:0] cd_out,
    output logic [7:0] r_out,
    output logic [7:0] g_out,
    output logic [7:0] b_out
);

    // One extra bit keeps the upper bound from wrapping for origins near the raster edge.
    localparam logic [10:0] X_LO = 11'(ORIGIN_X);
    localparam logic [10:0] X_HI = 11'(ORIGIN_X + (BOARD_COLS << CELL_SHIFT));
    localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
    localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + (BOARD_ROWS << CELL_SHIFT));

    logic [10:0]      x_ext;
    logic [10:0]      y_ext;
    logic [10:0]      dx;
    logic [10:0]      dy;
    logic             in_board_next;
    logic [COL_W-1:0] col_next;
    logic [ROW_W-1:0] row_next;

    logic             vde1_reg;
    logic [1:0]       cd1_reg;
    logic             in_board1_reg;
    logic [COL_W-1:0] col1_reg;
    logic [ROW_W-1:0] row1_reg;

    logic             vde2_reg;
    logic [1:0]       cd2_reg;
    logic             in_board2_reg;

    color_idx_t       cell_color;
    rgb_t             pix_rgb;

    always_comb begin
        x_ext         = {1'b0, x_in};
        y_ext         = {1'b0, y_in};
        dx            = x_ext - X_LO;
        dy            = y_ext - Y_LO;
        in_board_next = (x_ext >= X_LO) && (x_ext < X_HI) &&
                        (y_ext >= Y_LO) && (y_ext < Y_HI);
        col_next      = '0;
        row_next      = '0;
        if (in_board_next) begin
            col_next = COL_W'(dx >> CELL_SHIFT);
            row_next = ROW_W'(dy >> CELL_SHIFT);
        end
    end

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            vde1_reg      <= 1'b0;
            cd1_reg       <= 2'b00;
            in_board1_reg <= 1'b0;
            col1_reg      <= '0;
            row1_reg      <= '0;
            vde2_reg      <= 1'b0;
            cd2_reg       <= 2'b00;
            in_board2_reg <= 1'b0;
        end else begin
            vde1_reg      <= vde_in;
            cd1_reg       <= cd_in;
            in_board1_reg <= in_board_next;
            col1_reg      <= col_next;
            row1_reg      <= row_next;
            vde2_reg      <= vde1_reg;
            cd2_reg       <= cd1_reg;
            in_board2_reg <= in_board1_reg;
        end
    end

`ifdef TETRIS_GRID_LINES_EN
    logic grid_next;
    logic grid1_reg;
    logic grid2_reg;

    assign grid_next = (dx[CELL_SHIFT-1:0] == '0) || (dy[CELL_SHIFT-1:0] == '0);

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            grid1_reg <= 1'b0;
            grid2_reg <= 1'b0;
        end else begin
            grid1_reg <= grid_next;
            grid2_reg <= grid1_reg;
        end
    end
`endif

    // The RAM read register is the stage-2 cell lookup, aligned with the *2_reg flags.
    tetris_board_ram u_board_ram (
        .clk      (pixclk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_col   (wr_col),
        .wr_row   (wr_row),
        .wr_color (color_idx_t'(wr_color)),
        .rd_col   (col1_reg),
        .rd_row   (row1_reg),
        .rd_color (cell_color)
    );

    always_comb begin
        pix_rgb = RGB_BLACK;
        if (vde2_reg) begin
            if (!in_board2_reg) begin
                pix_rgb = BG_RGB;
            end else begin
                pix_rgb = palette_lookup(cell_color);
`ifdef TETRIS_GRID_LINES_EN
                if (grid2_reg) begin
                    pix_rgb = GRID_RGB;
                end
`endif
            end
        end
    end

    assign vde_out = vde2_reg;
    assign cd_out  = cd2_reg;
    assign r_out   = pix_rgb.r;
    assign g_out   = pix_rgb.g;
    assign b_out   = pix_rgb.b;

endmodule

// File: tb/tb_tetris_pixel_renderer.sv
// Self-checking bench for tetris_pixel_renderer: directed steps plus randomized pixels/writes.
module tb_tetris_pixel_renderer;

    localparam int OX = 240;
    localparam int OY = 80;

    logic       pixclk = 1'b0;
    logic       rst_n;
    logic       vde_in;
    logic [1:0] cd_in;
    logic [9:0] x_in;
    logic [9:0] y_in;
    logic       wr_en;
    logic [3:0] wr_col;
    logic [4:0] wr_row;
    logic [2:0] wr_color;
    logic       vde_out;
    logic [1:0] cd_out;
    logic [7:0] r_out;
    logic [7:0] g_out;
    logic [7:0] b_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit       vde;
        bit [1:0] cd;
        int       x;
        int       y;
    } pix_t;

    pix_t        pend_q[$];
    int          board [10][20];
    logic [23:0] pal [8] = '{24'h000000, 24'h00FFFF, 24'hFFFF00, 24'h8000FF,
                             24'h00FF00, 24'hFF0000, 24'h0000FF, 24'hFF8000};

    always #5 pixclk = ~pixclk;

    tetris_pixel_renderer #(
        .ORIGIN_X   (OX),
        .ORIGIN_Y   (OY),
        .CELL_SHIFT (4)
    ) dut (
        .pixclk   (pixclk),
        .rst_n    (rst_n),
        .vde_in   (vde_in),
        .cd_in    (cd_in),
        .x_in     (x_in),
        .y_in     (y_in),
        .wr_en    (wr_en),
        .wr_col   (wr_col),
        .wr_row   (wr_row),
        .wr_color (wr_color),
        .vde_out  (vde_out),
        .cd_out   (cd_out),
        .r_out    (r_out),
        .g_out    (g_out),
        .b_out    (b_out)
    );

    function automatic logic [23:0] model_rgb(input pix_t p);
        int cx;
        int cy;
        if (!p.vde) return 24'h000000;
        if (p.x < OX || p.x >= OX + 160 || p.y < OY || p.y >= OY + 320) return 24'h111111;
        cx = (p.x - OX) / 16;
        cy = (p.y - OY) / 16;
`ifdef TETRIS_GRID_LINES_EN
        if ((p.x - OX) % 16 == 0 || (p.y - OY) % 16 == 0) return 24'h404040;
`endif
        return pal[board[cx][cy]];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pix_t z;
        z = '{1'b0, 2'b00, 0, 0};
        for (int c = 0; c < 10; c++) begin
            for (int r = 0; r < 20; r++) begin
                board[c][r] = 0;
            end
        end
        pend_q.delete();
        pend_q.push_back(z);
    endtask

    // One pixel clock: drive inputs, clock, then compare the pixel issued one call earlier.
    task automatic cycle(input bit vde, input bit [1:0] cd, input int x, input int y,
                         input bit wen, input int wcol, input int wrow, input int wcolor);
        pix_t        p;
        pix_t        e;
        logic [23:0] exp_rgb;
        vde_in   = vde;
        cd_in    = cd;
        x_in     = 10'(x);
        y_in     = 10'(y);
        wr_en    = wen;
        wr_col   = 4'(wcol);
        wr_row   = 5'(wrow);
        wr_color = 3'(wcolor);
        p = '{vde, cd, x, y};
        pend_q.push_back(p);
        @(posedge pixclk);
        #1;
        e = pend_q.pop_front();
        exp_rgb = model_rgb(e);
        if (wen && wcol < 10 && wrow < 20) board[wcol][wrow] = wcolor;
        check("vde_out", 32'(vde_out), 32'(e.vde));
        check("cd_out", 32'(cd_out), 32'(e.cd));
        check("rgb", 32'({r_out, g_out, b_out}), 32'(exp_rgb));
        $display("px x=%0d y=%0d vde=%0d wr=%0d(%0d,%0d,%0d) -> vde=%0d cd=%0d rgb=%h",
                 e.x, e.y, e.vde, wen, wcol, wrow, wcolor, vde_out, cd_out, {r_out, g_out, b_out});
    endtask

    task automatic random_cycles(input int n);
        int x;
        int y;
        for (int i = 0; i < n; i++) begin
            x = ($urandom_range(0, 1) != 0) ? int'($urandom_range(230, 410)) : int'($urandom_range(0, 1023));
            y = ($urandom_range(0, 1) != 0) ? int'($urandom_range(70, 410)) : int'($urandom_range(0, 1023));
            cycle(($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)), x, y,
                  ($urandom_range(0, 2) == 0), int'($urandom_range(0, 11)),
                  int'($urandom_range(0, 21)), int'($urandom_range(0, 7)));
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        vde_in   = 1'b0;
        cd_in    = 2'b00;
        x_in     = '0;
        y_in     = '0;
        wr_en    = 1'b0;
        wr_col   = '0;
        wr_row   = '0;
        wr_color = '0;
        model_reset();
        #1;
        check("reset_vde", 32'(vde_out), 32'h0);
        check("reset_cd", 32'(cd_out), 32'h0);
        check("reset_rgb", 32'({r_out, g_out, b_out}), 32'h0);
        @(posedge pixclk);
        @(posedge pixclk);
        #1;
        rst_n = 1'b1;

        // Background outside the board
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        check("bg_vde", 32'(vde_out), 32'h1);
        check("bg_rgb", 32'({r_out, g_out, b_out}), 32'h111111);

        // Red cell at (0,0), then both horizontal edges of the board
        cycle(1, 0, 0, 0, 1, 0, 0, 5);
        cycle(1, 0, 245, 85, 0, 0, 0, 0);
        cycle(1, 0, 239, 85, 0, 0, 0, 0);
        check("cell00_red", 32'({r_out, g_out, b_out}), 32'hFF0000);
        cycle(1, 0, 400, 85, 0, 0, 0, 0);
        check("left_edge_bg", 32'({r_out, g_out, b_out}), 32'h111111);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        check("right_edge_bg", 32'({r_out, g_out, b_out}), 32'h111111);

        // Last cell, then an out-of-range column write that must not alias onto (0,1)
        cycle(1, 0, 399, 399, 1, 9, 19, 1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        check("cell919_cyan", 32'({r_out, g_out, b_out}), 32'h00FFFF);
        cycle(1, 0, 245, 101, 1, 10, 0, 3);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        check("col10_ignored", 32'({r_out, g_out, b_out}), 32'h000000);

        // Blanking with control data
        cycle(0, 2'b10, 300, 200, 0, 0, 0, 0);
        cycle(0, 2'b00, 0, 0, 0, 0, 0, 0);
        check("blank_vde", 32'(vde_out), 32'h0);
        check("blank_cd", 32'(cd_out), 32'h2);
        check("blank_rgb", 32'({r_out, g_out, b_out}), 32'h0);

        // Write colliding with the stage-2 read of the same cell
        cycle(1, 0, 293, 117, 0, 0, 0, 0);
        cycle(1, 0, 293, 117, 1, 3, 2, 4);
        check("collide_old", 32'({r_out, g_out, b_out}), 32'h000000);
        cycle(1, 0, 293, 117, 0, 0, 0, 0);
        check("collide_new", 32'({r_out, g_out, b_out}), 32'h00FF00);

        // Left edge pixel of red cell: grid line only when the feature is built in
        cycle(1, 0, 240, 85, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
`ifdef TETRIS_GRID_LINES_EN
        check("grid_edge", 32'({r_out, g_out, b_out}), 32'h404040);
`else
        check("grid_edge", 32'({r_out, g_out, b_out}), 32'hFF0000);
`endif

        random_cycles(500);

        // Asynchronous reset mid-frame
        cycle(1, 0, 245, 85, 1, 0, 0, 5);
        wr_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_vde", 32'(vde_out), 32'h0);
        check("midreset_cd", 32'(cd_out), 32'h0);
        check("midreset_rgb", 32'({r_out, g_out, b_out}), 32'h0);
        @(posedge pixclk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cycle(1, 0, 245, 85, 0, 0, 0, 0);
        check("post_reset_first_vde", 32'(vde_out), 32'h0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        check("post_reset_black", 32'({r_out, g_out, b_out}), 32'h000000);

        random_cycles(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tetris_pixel_renderer.md
TETRIS_PIXEL_RENDERER -- requirements
Module: tetris_pixel_renderer

Interface
REQ-001 SHALL have parameter ORIGIN_X, default 240, giving the board's left edge pixel column.
REQ-002 SHALL have parameter ORIGIN_Y, default 80, giving the board's top edge pixel row.
REQ-003 SHALL have parameter CELL_SHIFT, default 4, giving log2 of the cell size in pixels (16x16 cells).
REQ-004 SHALL use one clock and an asynchronous active-low reset; port list follows.
REQ-005 pixclk  in  1  pixel clock; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 vde_in  in  1  video data enable from timing generator.
REQ-008 cd_in  in  2  control data (hsync/vsync) from timing generator.
REQ-009 x_in, y_in  in  10 each  current pixel column/row.
REQ-010 wr_en  in  1  board cell write strobe from game logic.
REQ-011 wr_col  in  4; wr_row  in  5; wr_color  in  3  cell address and colour index (0 = empty).
REQ-012 vde_out  out  1; cd_out  out  2  vde_in/cd_in delayed to align with pixel data.
REQ-013 r_out, g_out, b_out  out  8 each  pixel data to TMDS encoders.

Function
REQ-014 SHALL hold a 10-column x 20-row board of 3-bit cell colours, all cleared to 0 by reset.
REQ-015 SHALL write wr_color into cell (wr_col, wr_row) on a pixclk edge with wr_en=1; writes with wr_col>=10 or wr_row>=20 ignored.
REQ-016 SHALL have fixed 2-cycle latency: inputs at edge N appear on all outputs after edge N+2; vde_out/cd_out delayed identically.
REQ-017 Stage 1 SHALL register in_board, cell column/row, intra-cell offset flags, vde, cd; stage 2 SHALL read cell and register RGB.
REQ-018 in_board SHALL be true iff ORIGIN_X <= x_in < ORIGIN_X+160 and ORIGIN_Y <= y_in < ORIGIN_Y+320; comparisons unsigned, no wrap-around.
REQ-019 Cell column = (x_in-ORIGIN_X)>>CELL_SHIFT, row = (y_in-ORIGIN_Y)>>CELL_SHIFT, computed only when in_board.
REQ-020 When delayed vde=0, RGB SHALL be 00/00/00 regardless of position.
REQ-021 When vde=1 and outside board, RGB SHALL be background 11/11/11.
REQ-022 When inside board, RGB SHALL follow palette: 0 black 000000, 1 00FFFF, 2 FFFF00, 3 8000FF, 4 00FF00, 5 FF0000, 6 0000FF, 7 FF8000.
REQ-023 Write and stage-2 read of same cell on same edge SHALL return the old colour; new colour visible from the next read.
REQ-024 Writes SHALL be accepted every cycle independent of vde, including during active video.

Reset
REQ-025 While rst_n=0: vde_out=0, cd_out=00, RGB=00/00/00, all pipeline registers and board cells 0, asserted immediately (asynchronous).
REQ-026 Reset mid-frame SHALL discard in-flight pixels; first valid output 2 edges after first sampled input post-release.

Configuration
REQ-027 Macro TETRIS_GRID_LINES_EN defined: in-board pixels whose x or y intra-cell offset is 0 SHALL render 40/40/40 irrespective of cell colour.
REQ-028 Macro undefined: no grid; cell colour fills the full 16x16 cell; latency unchanged.

Structure
REQ-029 Package tetris_video_pkg SHALL hold BOARD_COLS=10, BOARD_ROWS=20, colour-index type, palette constants, BG and GRID colours.
REQ-030 Board storage SHALL be sub-module tetris_board_ram (sync write, registered read, async clear); pipeline and palette in top.

Verification
REQ-031 Reset, then vde_in=1, x=0, y=0 -> two edges later vde_out=1, RGB=11/11/11.
REQ-032 Write (col0,row0,colour5); drive x=245, y=85 -> RGB=FF/00/00 two edges later; x=239 or x=400 -> 11/11/11.
REQ-033 Write (col9,row19,colour1); drive x=399, y=399 -> 00/FF/FF; write col=10 colour 3 -> no cell changes.
REQ-034 vde_in=0, cd_in=10 -> two edges later vde_out=0, cd_out=10, RGB=00/00/00.
REQ-035 Write colour 4 to a cell on the same edge stage 2 reads it -> old colour output that cycle, 00/FF/00 next read.
REQ-036 With TETRIS_GRID_LINES_EN: x=240, y=85, cell colour 5 -> 40/40/40; drop rst_n mid-frame -> outputs 0 immediately, board reads black afterwards.
